instruction_fetch: RTL and testbench

Instruction fetch unit that supplies the `instruction` input of the main control decoder and the rest of the decode stage. It owns the fetch PC, issues word reads to instruction memory over a request/response handshake with one outstanding request, and presents one registered instruction with its PC and a valid flag. It honours decode-stage stalls without losing a returned word, and on a taken branch it redirects and flushes wrong-path fetches.

---
 rtl/instruction_fetch.sv | 134 +++++++++++++
 tb/tb_instruction_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the fetch PC, runs a single-outstanding request/response
// handshake to instruction memory and presents one registered instruction to decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        instValid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetchState_t;

    fetchState_t state_r;
    logic [31:0] fetchPc_r;
    logic [31:0] reqPc_r;
    logic [31:0] instruction_r;
    logic [31:0] pc_r;
    logic        instValid_r;
    logic [31:0] skidData_r;
    logic [31:0] skidPc_r;
    logic        skidValid_r;

    logic        slotFree_s;
    logic        imemReq_s;
    logic        accept_s;
    logic [31:0] target_s;

    // Request gating: only ask for a word when the output slot can take it next cycle
    always_comb begin
        slotFree_s = !instValid_r || !stall;
        target_s   = branchTarget & 32'hFFFF_FFFC;
        if (!reset && (state_r == FETCH) && slotFree_s) begin
            imemReq_s = 1'b1;
        end else begin
            imemReq_s = 1'b0;
        end
        accept_s = imemReq_s && imemReady;
    end

    // Fetch sequencer, output slot and skid buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= FETCH;
            fetchPc_r     <= RESET_PC;
            reqPc_r       <= RESET_PC;
            instruction_r <= NOP_WORD;
            pc_r          <= RESET_PC;
            instValid_r   <= 1'b0;
            skidData_r    <= NOP_WORD;
            skidPc_r      <= RESET_PC;
            skidValid_r   <= 1'b0;
        end else if (branchTaken) begin
            // Redirect outranks stall, response and acceptance; an in-flight fetch is dropped
            fetchPc_r     <= target_s;
            instValid_r   <= 1'b0;
            instruction_r <= NOP_WORD;
            skidValid_r   <= 1'b0;
            case (state_r)
                FETCH:   state_r <= accept_s ? DROP : FETCH;
                WAIT:    state_r <= imemValid ? FETCH : DROP;
                default: state_r <= FETCH;
            endcase
        end else begin
            if (instValid_r && !stall) begin
                instValid_r   <= 1'b0;
                instruction_r <= NOP_WORD;
            end
            case (state_r)
                FETCH: begin
                    if (accept_s) begin
                        reqPc_r   <= fetchPc_r;
                        fetchPc_r <= fetchPc_r + 32'd4;
                        state_r   <= WAIT;
                    end
                end
                WAIT: begin
                    if (imemValid) begin
                        if (slotFree_s) begin
                            instruction_r <= imemData;
                            pc_r          <= reqPc_r;
                            instValid_r   <= 1'b1;
                            state_r       <= FETCH;
                        end else begin
                            skidData_r  <= imemData;
                            skidPc_r    <= reqPc_r;
                            skidValid_r <= 1'b1;
                            state_r     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (skidValid_r) begin
                            instruction_r <= skidData_r;
                            pc_r          <= skidPc_r;
                            instValid_r   <= 1'b1;
                        end
                        skidValid_r <= 1'b0;
                        state_r     <= FETCH;
                    end
                end
                DROP: begin
                    if (imemValid) begin
                        state_r <= FETCH;
                    end
                end
                default: state_r <= FETCH;
            endcase
        end
    end

    assign imemReq     = imemReq_s;
    assign imemAddr    = fetchPc_r;
    assign instruction = instruction_r;
    assign pc          = pc_r;
    assign instValid   = instValid_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: a memory model with random latency and a
// program-order reference stream (expected PC sequence, branch retargeting, reset restart).
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemValid;
    logic [31:0] imemData;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instValid;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference state: next PC in program order and how many fetched words the unit holds
    logic [31:0] expPc = RST_PC;
    int          words = 0;
    int          nConsumed = 0;
    int          cycleNo = 0;

    // Memory side: one outstanding read; pendDrop = unit waits to discard it, pendOrphan = unit ignores it
    bit          pendValid = 1'b0;
    bit          pendDrop = 1'b0;
    bit          pendOrphan = 1'b0;
    logic [31:0] pendAddr = 32'd0;
    int          pendDue = 0;

    bit          prevBranchIdle = 1'b0;
    logic [31:0] prevTarget = 32'd0;
    bit          prevReset = 1'b0;
    bit          prevHold = 1'b0;
    logic [31:0] prevAddr = 32'd0;

    int stallPct = 0;
    int readyPct = 100;
    int maxLat = 1;
    int branchPct = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC(RST_PC),
        .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imemReq(imemReq),
        .imemAddr(imemAddr),
        .imemReady(imemReady),
        .imemValid(imemValid),
        .imemData(imemData),
        .stall(stall),
        .branchTaken(branchTaken),
        .branchTarget(branchTarget),
        .instruction(instruction),
        .pc(pc),
        .instValid(instValid)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cycleNo);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive inputs, check outputs against the reference, advance the reference
    task automatic tick(input bit rst);
        bit          respNow;
        bit          consume;
        bit          accepted;
        bit          expReq;
        bit          idle;
        logic [31:0] tgt;

        reset       = rst;
        stall       = ($urandom_range(99) < stallPct);
        branchTaken = !rst && ($urandom_range(99) < branchPct);
        if ($urandom_range(1) == 1) begin
            tgt = 32'hFFFF_FFE0 + $urandom_range(31);
        end else begin
            tgt = $urandom;
        end
        branchTarget = tgt;
        respNow      = pendValid && (pendDue == cycleNo);
        imemValid    = respNow;
        imemData     = respNow ? memWord(pendAddr) : $urandom;
        imemReady    = !pendValid && ($urandom_range(99) < readyPct);
        #1;

        expReq = !rst && !(pendValid && !pendOrphan) && ((words == 0) || ((words == 1) && !stall));
        checkEq("imemReq", {31'd0, imemReq}, {31'd0, expReq});
        checkEq("instValid", {31'd0, instValid}, {31'd0, (words > 0)});
        if (words > 0) begin
            checkEq("pc", pc, expPc);
            checkEq("instruction", instruction, memWord(expPc));
        end else begin
            checkEq("nopWhenEmpty", instruction, NOP);
        end
        checkEq("addrAlign", {30'd0, imemAddr[1:0]}, 32'd0);
        if (prevBranchIdle && !rst) begin
            checkEq("redirectAddr", imemAddr, prevTarget);
        end
        if (prevReset) begin
            checkEq("resetAddr", imemAddr, RST_PC);
            checkEq("resetPc", pc, RST_PC);
        end
        if (prevHold) begin
            checkEq("addrStable", imemAddr, prevAddr);
        end

        accepted = !rst && imemReq && imemReady;
        consume  = !rst && !branchTaken && (words > 0) && !stall;
        idle     = !accepted && !(pendValid && !pendOrphan && !pendDrop && !respNow);

        prevHold = !rst && !branchTaken && imemReq && !imemReady;
        prevAddr = imemAddr;

        if (consume) begin
            expPc = expPc + 32'd4;
            words--;
            nConsumed++;
        end
        if (respNow) begin
            pendValid = 1'b0;
            if (!pendDrop && !pendOrphan) begin
                words++;
            end
        end
        if (accepted) begin
            pendValid  = 1'b1;
            pendDrop   = 1'b0;
            pendOrphan = 1'b0;
            pendAddr   = imemAddr;
            pendDue    = cycleNo + $urandom_range(maxLat, 1);
        end
        if (branchTaken) begin
            expPc = tgt & 32'hFFFF_FFFC;
            words = 0;
            if (pendValid && !pendOrphan) begin
                if (pendDrop) begin
                    pendOrphan = 1'b1;
                end else begin
                    pendDrop = 1'b1;
                end
            end
        end
        if (rst) begin
            expPc = RST_PC;
            words = 0;
            if (pendValid) begin
                pendOrphan = 1'b1;
            end
        end
        prevBranchIdle = branchTaken && idle;
        prevTarget     = tgt & 32'hFFFF_FFFC;
        prevReset      = rst;

        cycleNo++;
        @(posedge clk);
        #1;
    endtask

    // Run until a real fetch is in flight, then reset so its response arrives stale
    task automatic resetWhilePending();
        for (int i = 0; i < 60; i++) begin
            if (pendValid && !pendDrop && !pendOrphan && (pendDue > cycleNo)) begin
                break;
            end
            tick(1'b0);
        end
        tick(1'b1);
    endtask

    task automatic runPhase(input int cycles, input int sPct, input int rPct, input int lat, input int bPct);
        stallPct  = sPct;
        readyPct  = rPct;
        maxLat    = lat;
        branchPct = bPct;
        for (int i = 0; i < cycles; i++) begin
            tick(1'b0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        stall        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 32'd0;
        imemReady    = 1'b0;
        imemValid    = 1'b0;
        imemData     = 32'd0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
        end

        // Back-to-back stream from reset, crossing the 32-bit address wrap
        runPhase(40, 0, 100, 1, 0);
        resetWhilePending();
        runPhase(300, 50, 70, 4, 0);
        resetWhilePending();
        runPhase(1500, 30, 80, 3, 5);
        resetWhilePending();
        runPhase(1000, 70, 50, 5, 10);
        resetWhilePending();
        runPhase(400, 20, 100, 1, 3);

        checkEq("progress", {31'd0, (nConsumed > 200)}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
